// File: rtl/hdmi_period_scheduler.sv
// hdmi_period_scheduler: per-pixel TMDS period sequencer (control, video preamble/guard/active, data islands).
// Ports: clk/rst (sync, active-high); i_hcount/i_vcount/i_hsync/i_vsync from the sync generator;
// i_pkt_avail packets ready at the source; o_mode period type, o_ctl CTL3..0 preamble code,
// o_hsync/o_vsync/o_data_en for the encoders, o_pkt_bit bit index in packet, o_pkt_ack packet consumed.
module hdmi_period_scheduler #(
  parameter int HA = 640,
  parameter int HTOTAL = 800,
  parameter int VA = 480,
  parameter int VTOTAL = 525,
  parameter int DI_START = 660,
  parameter int MAX_PKTS = 2,
  localparam int HW = $clog2(HTOTAL),
  localparam int VW = $clog2(VTOTAL),
  localparam int PW = $clog2(MAX_PKTS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [HW-1:0] i_hcount,
  input  logic [VW-1:0] i_vcount,
  input  logic          i_hsync,
  input  logic          i_vsync,
  input  logic [PW-1:0] i_pkt_avail,
  output logic [2:0]    o_mode,
  output logic [3:0]    o_ctl,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_data_en,
  output logic [4:0]    o_pkt_bit,
  output logic          o_pkt_ack
);
  if (DI_START < HA || DI_START + 12 + 32 * MAX_PKTS > HTOTAL - 10 || MAX_PKTS < 1 || MAX_PKTS > 4) begin : g_bad_params
    $error("hdmi_period_scheduler: island window overlaps video or MAX_PKTS outside 1..4");
  end
  typedef enum logic [2:0] {IDLE, PRE, GB_LEAD, DATA, GB_TRAIL} state_t;
  state_t st, cur;
  logic [2:0] cnt, cc;
  logic [4:0] bit_cnt;
  logic [PW-1:0] pkt_cnt, n;
  logic [VW-1:0] nv;
  logic start, vpre_line, vid, vpre, vgb;
  logic [2:0] mode;
  // cur is the island phase of the pixel presented this cycle; the start pixel itself is already PRE.
  always_comb begin
    start = st == IDLE && i_hcount == HW'(DI_START) && i_pkt_avail != '0;
    cur = start ? PRE : st;
    cc = start ? 3'd0 : cnt;
    nv = i_vcount == VW'(VTOTAL - 1) ? '0 : i_vcount + 1'b1;
    vpre_line = nv < VW'(VA);
    vid = i_hcount < HW'(HA) && i_vcount < VW'(VA);
    vpre = vpre_line && i_hcount >= HW'(HTOTAL - 10) && i_hcount <= HW'(HTOTAL - 3);
    vgb = vpre_line && i_hcount >= HW'(HTOTAL - 2);
    mode = cur == PRE ? 3'd4 : cur == GB_LEAD ? 3'd5 : cur == DATA ? 3'd6 : cur == GB_TRAIL ? 3'd7 :
           vid ? 3'd3 : vpre ? 3'd1 : vgb ? 3'd2 : 3'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      cnt <= '0;
      bit_cnt <= '0;
      pkt_cnt <= '0;
      n <= '0;
      o_mode <= '0;
      o_ctl <= '0;
      o_hsync <= 1'b0;
      o_vsync <= 1'b0;
      o_data_en <= 1'b0;
      o_pkt_bit <= '0;
      o_pkt_ack <= 1'b0;
    end else begin
      o_mode <= mode;
      o_ctl <= mode == 3'd1 ? 4'b0001 : mode == 3'd4 ? 4'b0101 : 4'b0000;
      o_hsync <= i_hsync;
      o_vsync <= i_vsync;
      o_data_en <= mode == 3'd3;
      o_pkt_bit <= cur == DATA ? bit_cnt : 5'd0;
      o_pkt_ack <= cur == DATA && bit_cnt == 5'd31;
      if (start) n <= i_pkt_avail > PW'(MAX_PKTS) ? PW'(MAX_PKTS) : i_pkt_avail;
      st <= cur;
      case (cur)
        PRE: begin
          cnt <= cc + 3'd1;
          if (cc == 3'd7) begin
            st <= GB_LEAD;
            cnt <= '0;
          end
        end
        GB_LEAD: begin
          cnt <= cc + 3'd1;
          if (cc == 3'd1) begin
            st <= DATA;
            cnt <= '0;
            bit_cnt <= '0;
            pkt_cnt <= '0;
          end
        end
        DATA: begin
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt == 5'd31) begin
            pkt_cnt <= pkt_cnt + 1'b1;
            if (pkt_cnt + 1'b1 == n) st <= GB_TRAIL;
          end
        end
        GB_TRAIL: begin
          cnt <= cc + 3'd1;
          if (cc == 3'd1) begin
            st <= IDLE;
            cnt <= '0;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end
endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// tb_hdmi_period_scheduler: randomized self-checking bench against a line-offset reference model.
module tb_hdmi_period_scheduler;
  localparam int HA = 640, HTOTAL = 800, VA = 480, VTOTAL = 525, DI_START = 660, MAXP = 2;
  logic clk = 1'b0;
  logic rst;
  logic [9:0] i_hcount, i_vcount;
  logic i_hsync, i_vsync;
  logic [1:0] i_pkt_avail;
  logic [2:0] o_mode;
  logic [3:0] o_ctl;
  logic o_hsync, o_vsync, o_data_en, o_pkt_ack;
  logic [4:0] o_pkt_bit;
  logic [15:0] got, exp_vec;
  int vectors = 0, miscompares = 0;
  int h, v, last_h, nn;
  bit act;

  hdmi_period_scheduler #(.HA(HA), .HTOTAL(HTOTAL), .VA(VA), .VTOTAL(VTOTAL), .DI_START(DI_START), .MAX_PKTS(MAXP)) dut (
    .clk(clk), .rst(rst), .i_hcount(i_hcount), .i_vcount(i_vcount), .i_hsync(i_hsync), .i_vsync(i_vsync),
    .i_pkt_avail(i_pkt_avail), .o_mode(o_mode), .o_ctl(o_ctl), .o_hsync(o_hsync), .o_vsync(o_vsync),
    .o_data_en(o_data_en), .o_pkt_bit(o_pkt_bit), .o_pkt_ack(o_pkt_ack));

  always #5 clk = ~clk;
  assign got = {o_mode, o_ctl, o_hsync, o_vsync, o_data_en, o_pkt_bit, o_pkt_ack};

  // Reference: an island is a window of 12+32N pixels starting at DI_START; modes follow from the offset.
  task automatic step(input logic r, input int a);
    int d;
    logic [2:0] m;
    logic [3:0] c;
    logic [4:0] b;
    logic k, hs, vs, nl;
    hs = h >= 656 && h < 752;
    vs = v >= 490 && v < 492;
    rst = r;
    i_hcount = h[9:0];
    i_vcount = v[9:0];
    i_hsync = hs;
    i_vsync = vs;
    i_pkt_avail = a[1:0];
    m = 3'd0; c = 4'd0; b = 5'd0; k = 1'b0;
    if (r) act = 1'b0;
    else begin
      if (!act && h == DI_START && a != 0) begin
        act = 1'b1;
        nn = a > MAXP ? MAXP : a;
      end
      d = h - DI_START;
      if (act && d >= 0 && d < 12 + 32 * nn) begin
        if (d < 8) begin m = 3'd4; c = 4'b0101; end
        else if (d < 10) m = 3'd5;
        else if (d < 10 + 32 * nn) begin m = 3'd6; b = 5'((d - 10) % 32); k = b == 5'd31; end
        else m = 3'd7;
        if (d == 11 + 32 * nn) act = 1'b0;
      end else begin
        nl = ((v + 1) % VTOTAL) < VA;
        if (h < HA && v < VA) m = 3'd3;
        else if (nl && h >= HTOTAL - 10 && h <= HTOTAL - 3) begin m = 3'd1; c = 4'b0001; end
        else if (nl && h >= HTOTAL - 2) m = 3'd2;
      end
    end
    exp_vec = r ? 16'd0 : {m, c, hs, vs, m == 3'd3, b, k};
    last_h = h;
    @(posedge clk);
    #1;
    h = h + 1;
    if (h == HTOTAL) begin
      h = 0;
      v = (v + 1) % VTOTAL;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      h = $urandom_range(0, HTOTAL - 1);
      v = $urandom_range(0, VTOTAL - 1);
      step(1'b1, $urandom_range(0, 3));
      vectors++;
      if (got !== exp_vec || got !== 16'd0) begin
        miscompares++;
        $display("FAIL reset h=%0d v=%0d got=%h exp=%h", last_h, v, got, exp_vec);
      end
    end
  endtask

  task automatic test_no_packets();
    int lines[10] = '{523, 524, 0, 1, 2, 239, 478, 479, 480, 481};
    int de, pre, gb, di;
    foreach (lines[j]) begin
      v = lines[j];
      h = 0;
      de = 0; pre = 0; gb = 0; di = 0;
      for (int i = 0; i < HTOTAL; i++) begin
        step(1'b0, 0);
        vectors++;
        if (got !== exp_vec) begin
          miscompares++;
          $display("FAIL no_pkt h=%0d v=%0d got=%h exp=%h", last_h, lines[j], got, exp_vec);
        end
        de += o_data_en;
        pre += (o_mode == 3'd1 && o_ctl == 4'b0001);
        gb += (o_mode == 3'd2);
        di += (o_mode >= 3'd4 || (o_ctl != 4'd0 && o_mode != 3'd1));
      end
      vectors++;
      if (de != (lines[j] < VA ? 640 : 0) || pre != (((lines[j] + 1) % VTOTAL) < VA ? 8 : 0) ||
          gb != (((lines[j] + 1) % VTOTAL) < VA ? 2 : 0) || di != 0) begin
        miscompares++;
        $display("FAIL line_counts v=%0d got de=%0d pre=%0d gb=%0d di=%0d", lines[j], de, pre, gb, di);
      end
    end
  endtask

  task automatic test_single_packet();
    int acks, ack_h, dpre;
    v = 100; h = 0; acks = 0; ack_h = -1; dpre = 0;
    for (int i = 0; i < HTOTAL; i++) begin
      step(1'b0, h == DI_START ? 1 : 0);
      vectors++;
      if (got !== exp_vec) begin
        miscompares++;
        $display("FAIL single h=%0d got=%h exp=%h", last_h, got, exp_vec);
      end
      if (o_pkt_ack) begin acks++; ack_h = last_h; end
      dpre += (o_mode == 3'd4 && o_ctl == 4'b0101 && last_h >= 660 && last_h <= 667);
    end
    vectors++;
    if (acks != 1 || ack_h != 701 || dpre != 8) begin
      miscompares++;
      $display("FAIL single_summary got acks=%0d at h=%0d pre=%0d exp 1 at 701 pre=8", acks, ack_h, dpre);
    end
  endtask

  task automatic test_multi_packet();
    int acks, data, a0, a1;
    v = 101; h = 0; acks = 0; data = 0; a0 = -1; a1 = -1;
    for (int i = 0; i < HTOTAL; i++) begin
      step(1'b0, h <= 670 ? 3 : 0);
      vectors++;
      if (got !== exp_vec) begin
        miscompares++;
        $display("FAIL multi h=%0d got=%h exp=%h", last_h, got, exp_vec);
      end
      data += (o_mode == 3'd6);
      if (o_pkt_ack) begin
        if (acks == 0) a0 = last_h; else a1 = last_h;
        acks++;
      end
    end
    vectors++;
    if (acks != 2 || data != 64 || a1 - a0 != 32) begin
      miscompares++;
      $display("FAIL multi_summary got acks=%0d data=%0d gap=%0d exp 2/64/32", acks, data, a1 - a0);
    end
  endtask

  task automatic test_vblank_island();
    int last_di, pre, gb;
    v = 524; h = 0; last_di = -1; pre = 0; gb = 0;
    for (int i = 0; i < HTOTAL; i++) begin
      step(1'b0, h == DI_START ? 2 : $urandom_range(0, 3));
      vectors++;
      if (got !== exp_vec) begin
        miscompares++;
        $display("FAIL vblank h=%0d got=%h exp=%h", last_h, got, exp_vec);
      end
      if (o_mode >= 3'd4) last_di = last_h;
      pre += (o_mode == 3'd1 && last_h >= 790 && last_h <= 797);
      gb += (o_mode == 3'd2 && last_h >= 798);
    end
    vectors++;
    if (last_di != 735 || pre != 8 || gb != 2) begin
      miscompares++;
      $display("FAIL vblank_summary got last_di=%0d pre=%0d gb=%0d exp 735/8/2", last_di, pre, gb);
    end
  endtask

  task automatic test_reset_mid_island();
    int acks, ack_h;
    v = 200; h = 0;
    while (h <= 680) begin
      step(1'b0, 1);
      vectors++;
      if (got !== exp_vec) begin
        miscompares++;
        $display("FAIL mid_pre h=%0d got=%h exp=%h", last_h, got, exp_vec);
      end
    end
    vectors++;
    if (o_pkt_bit !== 5'd10 || o_mode !== 3'd6) begin
      miscompares++;
      $display("FAIL mid_bit got bit=%0d mode=%0d exp bit=10 mode=6", o_pkt_bit, o_mode);
    end
    step(1'b1, 1);
    vectors++;
    if (got !== 16'd0) begin
      miscompares++;
      $display("FAIL mid_reset got=%h exp=0000", got);
    end
    acks = 0; ack_h = -1;
    for (int i = 0; i < 2 * HTOTAL - 682; i++) begin
      step(1'b0, 1);
      vectors++;
      if (got !== exp_vec) begin
        miscompares++;
        $display("FAIL mid_post h=%0d v=%0d got=%h exp=%h", last_h, v, got, exp_vec);
      end
      if (o_pkt_ack) begin acks++; ack_h = last_h; end
    end
    vectors++;
    if (acks != 1 || ack_h != 701) begin
      miscompares++;
      $display("FAIL mid_next_island got acks=%0d at h=%0d exp 1 at 701", acks, ack_h);
    end
  endtask

  task automatic test_random();
    for (int j = 0; j < 12; j++) begin
      v = $urandom_range(0, VTOTAL - 1);
      h = 0;
      for (int i = 0; i < HTOTAL; i++) begin
        step(1'b0, $urandom_range(0, 3));
        vectors++;
        if (got !== exp_vec) begin
          miscompares++;
          $display("FAIL random h=%0d got=%h exp=%h", last_h, got, exp_vec);
        end
      end
    end
  endtask

  initial begin
    act = 1'b0;
    nn = 0;
    h = 0;
    v = 0;
    rst = 1'b1;
    i_hcount = '0;
    i_vcount = '0;
    i_hsync = 1'b0;
    i_vsync = 1'b0;
    i_pkt_avail = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_no_packets();
    test_single_packet();
    test_multi_packet();
    test_vblank_island();
    test_reset_mid_island();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/hdmi_period_scheduler.md
Name: hdmi_period_scheduler

Overview:
- Sequences the TMDS period type (control, video preamble/guard/data, data-island preamble/guard/data) for every pixel clock.
- Sits between the pixel counter/sync controller and the three TMDS channel encoders.
- Inserts data islands carrying packets (InfoFrames, audio) into horizontal blanking when packets are pending.
- Drives CTL preamble codes, a per-cycle mode select, and a packet fetch handshake.

Parameters:
- HA, 640, active pixels per line.
- HTOTAL, 800, total pixels per line.
- VA, 480, active lines.
- VTOTAL, 525, total lines.
- DI_START, 660, input hcount at which a data-island preamble may begin.
- MAX_PKTS, 2, maximum packets per island (1..4).

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous active-high reset.
- i_hcount  in  $clog2(HTOTAL)  current pixel column; 0..HA-1 is active.
- i_vcount  in  $clog2(VTOTAL)  current line; 0..VA-1 is active.
- i_hsync  in  1  hsync aligned to i_hcount.
- i_vsync  in  1  vsync aligned to i_hcount.
- i_pkt_avail  in  $clog2(MAX_PKTS+1)  number of packets the packet source holds ready.
- o_mode  out  3  0 CTRL, 1 VID_PRE, 2 VID_GB, 3 VID, 4 DI_PRE, 5 DI_GB_LEAD, 6 DI_DATA, 7 DI_GB_TRAIL.
- o_ctl  out  4  {CTL3,CTL2,CTL1,CTL0} for the green and red channels.
- o_hsync  out  1  registered i_hsync.
- o_vsync  out  1  registered i_vsync.
- o_data_en  out  1  high iff o_mode==VID.
- o_pkt_bit  out  5  bit index 0..31 within the current packet; 0 outside DI_DATA.
- o_pkt_ack  out  1  one-cycle pulse on the last cycle (bit 31) of each packet; consumes one packet.

Behaviour:
- All outputs are registered with 1-cycle latency: outputs at cycle n+1 describe the i_hcount/i_vcount presented at cycle n.
- Reset (synchronous):
  - o_mode=CTRL; o_ctl, o_hsync, o_vsync, o_data_en, o_pkt_bit and o_pkt_ack = 0.
  - Island FSM goes to IDLE and the latched packet count clears.
  - Reset mid-island abandons the island: next cycle is CTRL, with no trailing guard and no further o_pkt_ack.
- Video (combinational on the inputs, then registered):
  - h<HA and v<VA gives VID.
  - For a line v where (v+1) mod VTOTAL < VA:
    - h in HTOTAL-10..HTOTAL-3 gives VID_PRE with o_ctl=4'b0001.
    - h in HTOTAL-2..HTOTAL-1 gives VID_GB.
- Island FSM states: IDLE, PRE, GB_LEAD, DATA, GB_TRAIL.
  - IDLE -> PRE when i_hcount==DI_START and i_pkt_avail!=0 (on any line, including vertical blanking). Latch N=min(i_pkt_avail, MAX_PKTS).
  - PRE lasts 8 cycles with o_ctl=4'b0101.
  - GB_LEAD lasts 2 cycles.
  - DATA lasts 32*N cycles. o_pkt_bit counts 0..31 and wraps per packet; o_pkt_ack is high when o_pkt_bit==31.
  - GB_TRAIL lasts 2 cycles, then IDLE.
- Changes to i_pkt_avail after the latch are ignored until the next island.
- At most one island per line. i_pkt_avail==0 at DI_START means no island on that line.
- o_ctl=0 in every mode except VID_PRE and DI_PRE.
- Elaboration $error if any of the following holds:
  - DI_START < HA.
  - DI_START + 12 + 32*MAX_PKTS > HTOTAL-10.
  - MAX_PKTS is outside 1..4.
  - These checks guarantee islands never overlap video preamble/guard/active.
- Counter widths:
  - Packet-bit counter: 5 bits, wrapping.
  - Packet counter: $clog2(MAX_PKTS+1) bits, compared against N for the DATA->GB_TRAIL transition.
- i_hsync and i_vsync pass through in every mode; in DI modes the channel-0 encoder still uses them.

Test Plan:
- Reset, then run counts from (0,0) with i_pkt_avail=0 for one frame -> no DI modes ever. Per line, o_data_en high for 640 cycles. VID_PRE for 8 cycles and VID_GB for 2 before each of lines 0..479 (preamble on lines 524 and 0..478). o_ctl=4'b0001 only during VID_PRE.
- i_pkt_avail=1 at h=660, v=100 -> DI_PRE outputs at h=660..667 (o_ctl=4'b0101), GB_LEAD at 668..669, DATA at 670..701, GB_TRAIL at 702..703. Exactly one o_pkt_ack, at h=701 with o_pkt_bit=31.
- i_pkt_avail=3 at DI_START with MAX_PKTS=2 -> DATA lasts 64 cycles, with 2 o_pkt_ack pulses 32 cycles apart. i_pkt_avail dropping to 0 mid-island does not shorten it.
- Island on line 524 (vertical blanking) -> island completes by h=735, then the VID_PRE/VID_GB sequence at h=790..799 is intact.
- rst asserted at o_pkt_bit=10 of packet 0 -> next cycle o_mode=CTRL, all outputs 0, no ack. With rst released and i_pkt_avail=1, the next island starts at the following line's DI_START.
- Parameter sweep DI_START=700, MAX_PKTS=3 -> elaboration error (700+12+96 > 790).
